// File: rtl/uart_rx_core.sv
// UART receive engine: 16x oversampled, 7/8 data bits, optional parity, one stop bit.
// Define RX_MAJORITY_VOTE_EN to take each bit as a 2-of-3 vote around its centre sample.
module uart_rx_core #(
    parameter int unsigned RX_SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       baud_clock,
    input  logic       rx,
    input  logic       bit8,
    input  logic       parity_en,
    input  logic       odd_n_even,
    input  logic       read_rx_byte,
    output logic [7:0] rx_data,
    output logic       rx_data_valid,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);

    typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;

    state_e                    r_state;
    state_e                    w_state_next;
    logic [RX_SYNC_STAGES-1:0] r_sync;
    logic                      r_rx_prev;
    logic [3:0]                r_samp_cnt;
    logic [2:0]                r_bit_cnt;
    logic [7:0]                r_shift;
    logic                      r_bit8;
    logic                      r_par_en;
    logic                      r_odd;
    logic                      r_par_mis;
    logic [7:0]                r_data;
    logic                      r_valid;
    logic                      r_par_err;
    logic                      r_frm_err;
    logic                      r_ovf;

    logic w_rx_s;
    logic w_fall;
    logic w_mid;
    logic w_start_mid;
    logic w_bit;
    logic w_start_ok;
    logic w_shift_en;
    logic w_par_cap;
    logic w_done;
    logic w_load;

    assign w_rx_s      = r_sync[RX_SYNC_STAGES-1];
    assign w_fall      = r_rx_prev & ~w_rx_s;
    assign w_mid       = baud_clock && (r_samp_cnt == 4'd15);
    assign w_start_mid = baud_clock && (r_samp_cnt == 4'd7);
    assign w_load      = ~r_valid | read_rx_byte;

`ifdef RX_MAJORITY_VOTE_EN
    logic [1:0] r_vote;

    // Start bit votes on ticks 5/6/7, other bits on 13/14/15.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_vote <= 2'b00;
        end else if (baud_clock) begin
            if (r_samp_cnt == ((r_state == StStart) ? 4'd5 : 4'd13)) r_vote[0] <= w_rx_s;
            if (r_samp_cnt == ((r_state == StStart) ? 4'd6 : 4'd14)) r_vote[1] <= w_rx_s;
        end
    end

    assign w_bit = (r_vote[0] & r_vote[1]) | (r_vote[0] & w_rx_s) | (r_vote[1] & w_rx_s);
`else
    assign w_bit = w_rx_s;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            StIdle:   if (w_fall) w_state_next = StStart;
            StStart:  if (w_start_mid) w_state_next = w_bit ? StIdle : StData;
            StData: begin
                if (w_mid && (r_bit_cnt == (r_bit8 ? 3'd7 : 3'd6))) begin
                    w_state_next = r_par_en ? StParity : StStop;
                end
            end
            StParity: if (w_mid) w_state_next = StStop;
            StStop:   if (w_mid) w_state_next = StIdle;
            default:  w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_start_ok = 1'b0;
        w_shift_en = 1'b0;
        w_par_cap  = 1'b0;
        w_done     = 1'b0;
        unique case (r_state)
            StStart:  w_start_ok = w_start_mid & ~w_bit;
            StData:   w_shift_en = w_mid;
            StParity: w_par_cap  = w_mid;
            StStop:   w_done     = w_mid;
            default:  ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync     <= '1;
            r_rx_prev  <= 1'b1;
            r_samp_cnt <= 4'd0;
            r_bit_cnt  <= 3'd0;
            r_shift    <= 8'h00;
            r_bit8     <= 1'b0;
            r_par_en   <= 1'b0;
            r_odd      <= 1'b0;
            r_par_mis  <= 1'b0;
            r_data     <= 8'h00;
            r_valid    <= 1'b0;
            r_par_err  <= 1'b0;
            r_frm_err  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_sync    <= {r_sync[RX_SYNC_STAGES-2:0], rx};
            r_rx_prev <= w_rx_s;

            if ((r_state == StIdle && w_fall) || w_start_ok) begin
                r_samp_cnt <= 4'd0;
            end else if (baud_clock) begin
                r_samp_cnt <= r_samp_cnt + 4'd1;
            end

            // Frame format is latched once the start bit is confirmed.
            if (w_start_ok) begin
                r_bit_cnt <= 3'd0;
                r_shift   <= 8'h00;
                r_bit8    <= bit8;
                r_par_en  <= parity_en;
                r_odd     <= odd_n_even;
                r_par_mis <= 1'b0;
            end
            if (w_shift_en) begin
                r_shift[r_bit_cnt] <= w_bit;
                r_bit_cnt          <= r_bit_cnt + 3'd1;
            end
            if (w_par_cap) r_par_mis <= w_bit ^ (^r_shift) ^ r_odd;

            r_par_err <= 1'b0;
            r_frm_err <= 1'b0;
            r_ovf     <= 1'b0;
            if (read_rx_byte) r_valid <= 1'b0;
            if (w_done) begin
                if (w_load) begin
                    r_data  <= r_shift;
                    r_valid <= 1'b1;
                end else begin
                    r_ovf <= 1'b1;
                end
                r_frm_err <= ~w_bit;
                r_par_err <= r_par_mis;
            end
        end
    end

    assign rx_data       = r_data;
    assign rx_data_valid = r_valid;
    assign parity_err    = r_par_err;
    assign framing_err   = r_frm_err;
    assign overflow      = r_ovf;

endmodule

// File: tb/tb_uart_rx_core.sv
// Self-checking bench for uart_rx_core: directed and random frames against a frame-level model.
module tb_uart_rx_core;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       baud_clock = 1'b0;
    logic       rx = 1'b1;
    logic       bit8 = 1'b1;
    logic       parity_en = 1'b0;
    logic       odd_n_even = 1'b0;
    logic       read_rx_byte = 1'b0;
    logic [7:0] rx_data;
    logic       rx_data_valid;
    logic       parity_err;
    logic       framing_err;
    logic       overflow;

    int total = 0;
    int bad = 0;
    int phase = 0;
    int n_par = 0;
    int n_frm = 0;
    int n_ovf = 0;
    int n_wide = 0;
    logic pp = 1'b0;
    logic pf = 1'b0;
    logic po = 1'b0;

    // Reference model of the delivered character register.
    logic [7:0] m_data = 8'h00;
    bit         m_valid = 1'b0;

    uart_rx_core #(.RX_SYNC_STAGES(2)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .baud_clock   (baud_clock),
        .rx           (rx),
        .bit8         (bit8),
        .parity_en    (parity_en),
        .odd_n_even   (odd_n_even),
        .read_rx_byte (read_rx_byte),
        .rx_data      (rx_data),
        .rx_data_valid(rx_data_valid),
        .parity_err   (parity_err),
        .framing_err  (framing_err),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // Pulse counters; a pulse seen on two consecutive cycles counts as too wide.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (parity_err) n_par++;
            if (framing_err) n_frm++;
            if (overflow) n_ovf++;
            if ((parity_err && pp) || (framing_err && pf) || (overflow && po)) n_wide++;
            pp = parity_err;
            pf = framing_err;
            po = overflow;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // One clk cycle: drive inputs at the falling edge; baud pulse every 4th cycle.
    task automatic step(input logic rxv, input logic rd, output bit tick);
        @(negedge clk);
        rx           = rxv;
        read_rx_byte = rd;
        baud_clock   = (phase == 3);
        tick         = (phase == 3);
        phase        = (phase + 1) % 4;
    endtask

    task automatic idle(input int n, input logic rxv);
        bit tk;
        for (int i = 0; i < n; i++) step(rxv, 1'b0, tk);
    endtask

    // Bit j of the frame covers baud ticks 16j+1..16j+16 counted after edge detection,
    // so its centre is tick 16j+8. gl_tick inverts rx_s at exactly that one tick.
    task automatic send_frame(input logic [7:0] d, input bit b8, input bit pe, input bit odd,
                              input bit pflip, input logic stop_v, input bit rd_done,
                              input int gl_tick);
        logic bits [12];
        logic [7:0] dm;
        int nb;
        int s;
        int ticks;
        bit tk;
        logic rxv;
        logic rd;
        nb = b8 ? 8 : 7;
        dm = b8 ? d : {1'b0, d[6:0]};
        bits[0] = 1'b0;
        for (int i = 0; i < nb; i++) bits[i+1] = dm[i];
        s = nb + 1;
        if (pe) begin
            bits[s] = (^dm) ^ odd ^ pflip;
            s++;
        end
        bits[s] = stop_v;
        // Falling edge, two synchroniser cycles, then the edge-detect cycle.
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, tk);
        ticks = 0;
        while (ticks < 16 * s + 16) begin
            rxv = bits[ticks / 16];
            if (gl_tick != 0 && phase == 1 && ticks + 1 == gl_tick) rxv = ~rxv;
            rd = rd_done && (phase == 3) && (ticks + 1 == 8 + 16 * s);
            step(rxv, rd, tk);
            if (tk) ticks++;
        end
    endtask

    task automatic do_frame(input string tag, input logic [7:0] d, input bit b8, input bit pe,
                            input bit odd, input bit pflip, input logic stop_v,
                            input bit rd_done, input int gl_tick, input logic [7:0] flip_mask);
        int p0;
        int f0;
        int o0;
        logic [7:0] exp_b;
        bit load;
        p0 = n_par;
        f0 = n_frm;
        o0 = n_ovf;
        bit8       = b8;
        parity_en  = pe;
        odd_n_even = odd;
        send_frame(d, b8, pe, odd, pflip, stop_v, rd_done, gl_tick);
        idle(8, stop_v);
        exp_b = (b8 ? d : {1'b0, d[6:0]}) ^ flip_mask;
        load  = !m_valid || rd_done;
        if (load) begin
            m_data  = exp_b;
            m_valid = 1'b1;
        end
        check({tag, "/data"}, rx_data, m_data);
        check({tag, "/valid"}, rx_data_valid, m_valid);
        check({tag, "/parity_err"}, n_par - p0, pe && pflip);
        check({tag, "/framing_err"}, n_frm - f0, stop_v == 1'b0);
        check({tag, "/overflow"}, n_ovf - o0, !load);
    endtask

    task automatic read_byte();
        bit tk;
        step(1'b1, 1'b1, tk);
        m_valid = 1'b0;
        idle(2, 1'b1);
    endtask

    initial begin
        bit tk;
        int p0;
        int f0;
        int o0;
        logic [7:0] d;

        idle(4, 1'b1);
        check("reset/data", rx_data, 8'h00);
        check("reset/valid", rx_data_valid, 1'b0);
        check("reset/pulses", {parity_err, framing_err, overflow}, 3'b000);
        reset_n = 1'b1;
        idle(8, 1'b1);

        do_frame("8n1_a5", 8'hA5, 1, 0, 0, 0, 1'b1, 0, 0, 8'h00);
        read_byte();
        check("read/valid", rx_data_valid, m_valid);

        do_frame("7e1_bad", 8'h41, 0, 1, 0, 1, 1'b1, 0, 0, 8'h00);
        read_byte();
        do_frame("7e1_ok", 8'h41, 0, 1, 0, 0, 1'b1, 0, 0, 8'h00);
        read_byte();
        do_frame("7o1_ok", 8'hC3, 0, 1, 1, 0, 1'b1, 0, 0, 8'h00);
        read_byte();

        // Framing error, then the line stays low: no further frame may start.
        do_frame("frame_err", 8'h3C, 1, 0, 0, 0, 1'b0, 0, 0, 8'h00);
        f0 = n_frm;
        p0 = n_par;
        o0 = n_ovf;
        idle(400, 1'b0);
        check("break/valid", rx_data_valid, m_valid);
        check("break/data", rx_data, m_data);
        check("break/pulses", (n_frm - f0) + (n_par - p0) + (n_ovf - o0), 0);
        idle(20, 1'b1);
        read_byte();

        do_frame("ovf_first", 8'h11, 1, 0, 0, 0, 1'b1, 0, 0, 8'h00);
        do_frame("ovf_lost", 8'h22, 1, 0, 0, 0, 1'b1, 0, 0, 8'h00);
        do_frame("ovf_read", 8'h22, 1, 0, 0, 0, 1'b1, 1, 0, 8'h00);
        read_byte();

        // Start glitch of 3 baud ticks must be rejected.
        for (int i = 0; i < 12; i++) step(1'b0, 1'b0, tk);
        idle(200, 1'b1);
        check("glitch/valid", rx_data_valid, 1'b0);
        check("glitch/data", rx_data, m_data);

        // Single-tick glitch on data bit 0 of 0xFF.
        do_frame("gl14", 8'hFF, 1, 0, 0, 0, 1'b1, 0, 16 + 7, 8'h00);
        read_byte();
`ifdef RX_MAJORITY_VOTE_EN
        do_frame("gl15", 8'hFF, 1, 0, 0, 0, 1'b1, 0, 16 + 8, 8'h00);
`else
        do_frame("gl15", 8'hFF, 1, 0, 0, 0, 1'b1, 0, 16 + 8, 8'h01);
`endif

        // Reset in the middle of the data bits; valid is 1 beforehand.
        bit8      = 1'b1;
        parity_en = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, tk);
        for (int i = 0; i < 150; i++) step(i[4], 1'b0, tk);
        reset_n = 1'b0;
        #1;
        check("midreset/data", rx_data, 8'h00);
        check("midreset/valid", rx_data_valid, 1'b0);
        check("midreset/pulses", {parity_err, framing_err, overflow}, 3'b000);
        m_data  = 8'h00;
        m_valid = 1'b0;
        idle(4, 1'b1);
        reset_n = 1'b1;
        idle(8, 1'b1);
        do_frame("after_reset", 8'h5A, 1, 0, 0, 0, 1'b1, 0, 0, 8'h00);

        for (int i = 0; i < 16; i++) begin
            d = 8'($urandom);
            if (m_valid && ($urandom % 2 == 1)) read_byte();
            do_frame("rand", d, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                     1'b1, ($urandom % 4 == 0), 0, 8'h00);
        end

        check("pulse_width", n_wide, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
